// File: rtl/touch_event_filter_if.sv
// Touch event filter bus: raw samples from touch_controller in, queued events out.
// The master modport drives the filter inputs; the slave modport is the filter side.
interface touch_event_filter_if;
    logic        iTouch;
    logic        iTOUCH_IRQ;
    logic [11:0] iX_COORD;
    logic [11:0] iY_COORD;
    logic        iEVT_POP;
    logic        iCLR_OVF;
    logic        oEVT_VALID;
    logic [1:0]  oEVT_TYPE;
    logic [11:0] oEVT_X;
    logic [11:0] oEVT_Y;
    logic        oTOUCHING;
    logic        oOVERFLOW;

    modport master (
        output iTouch, iTOUCH_IRQ, iX_COORD, iY_COORD, iEVT_POP, iCLR_OVF,
        input  oEVT_VALID, oEVT_TYPE, oEVT_X, oEVT_Y, oTOUCHING, oOVERFLOW
    );

    modport slave (
        input  iTouch, iTOUCH_IRQ, iX_COORD, iY_COORD, iEVT_POP, iCLR_OVF,
        output oEVT_VALID, oEVT_TYPE, oEVT_X, oEVT_Y, oTOUCHING, oOVERFLOW
    );
endinterface

// File: rtl/touch_event_filter.sv
// Debounces touch contact, averages raw coordinates and queues PRESS/MOVE/RELEASE
// events in a FWFT FIFO. Define TOUCH_FILTER_MOVE_EN to enable MOVE event generation.
module touch_event_filter #(
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned RELEASE_CYCLES = 500000,
    parameter int unsigned MOVE_THRESH    = 8,
    parameter int unsigned FIFO_AW        = 2
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    touch_event_filter_if.slave  bus
);
    localparam int unsigned AccW  = 12 + AVG_LOG2;
    localparam int unsigned CntW  = AVG_LOG2 + 1;
    localparam int unsigned TmrW  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam int unsigned Depth = 1 << FIFO_AW;

    localparam logic [CntW-1:0] WinLen  = CntW'(1 << AVG_LOG2);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(RELEASE_CYCLES - 1);

    localparam logic [1:0] EvPress   = 2'b01;
    localparam logic [1:0] EvMove    = 2'b10;
    localparam logic [1:0] EvRelease = 2'b11;

    if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg
        $error("AVG_LOG2 must be in 1..4");
    end
    if (MOVE_THRESH > 4095) begin : g_bad_thresh
        $error("MOVE_THRESH must fit in 12 bits");
    end

    typedef enum logic [1:0] {StIdle, StArming, StPressed, StReleasing} state_e;

    state_e            state_q, state_d;
    logic [AccW-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [11:0]       last_x_q, last_x_d, last_y_q, last_y_d;
    logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic [25:0]       mem_q [Depth];

    logic              sample;
    logic [AccW-1:0]   sum_x, sum_y;
    logic [CntW-1:0]   cnt_inc;
    logic              win_done;
    logic [11:0]       avg_x, avg_y;
    logic              push;
    logic [1:0]        push_type;
    logic [11:0]       push_x, push_y;
    logic              empty, full, pop_ok, wr_en, drop;
    logic [25:0]       head;

    assign sample   = bus.iTOUCH_IRQ & bus.iTouch;
    assign sum_x    = acc_x_q + AccW'(bus.iX_COORD);
    assign sum_y    = acc_y_q + AccW'(bus.iY_COORD);
    assign cnt_inc  = cnt_q + CntW'(1);
    assign win_done = sample && (cnt_inc == WinLen);
    assign avg_x    = sum_x[AccW-1:AVG_LOG2];
    assign avg_y    = sum_y[AccW-1:AVG_LOG2];

`ifdef TOUCH_FILTER_MOVE_EN
    logic [12:0] dx, dy, adx, ady;
    logic        move_hit;

    // 13-bit two's complement differences; bit 12 is the sign.
    assign dx       = {1'b0, avg_x} - {1'b0, last_x_q};
    assign dy       = {1'b0, avg_y} - {1'b0, last_y_q};
    assign adx      = dx[12] ? (~dx + 13'd1) : dx;
    assign ady      = dy[12] ? (~dy + 13'd1) : dy;
    assign move_hit = (adx > 13'(MOVE_THRESH)) || (ady > 13'(MOVE_THRESH));
`endif

    always_comb begin
        state_d   = state_q;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        last_x_d  = last_x_q;
        last_y_d  = last_y_q;
        push      = 1'b0;
        push_type = 2'b00;
        push_x    = '0;
        push_y    = '0;
        unique case (state_q)
            StIdle: begin
                if (sample) begin
                    acc_x_d = AccW'(bus.iX_COORD);
                    acc_y_d = AccW'(bus.iY_COORD);
                    cnt_d   = CntW'(1);
                    state_d = StArming;
                end
            end
            StArming: begin
                if (!bus.iTouch) begin
                    acc_x_d = '0;
                    acc_y_d = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (win_done) begin
                    push      = 1'b1;
                    push_type = EvPress;
                    push_x    = avg_x;
                    push_y    = avg_y;
                    last_x_d  = avg_x;
                    last_y_d  = avg_y;
                    acc_x_d   = '0;
                    acc_y_d   = '0;
                    cnt_d     = '0;
                    state_d   = StPressed;
                end else if (sample) begin
                    acc_x_d = sum_x;
                    acc_y_d = sum_y;
                    cnt_d   = cnt_inc;
                end
            end
            StPressed: begin
                if (!bus.iTouch) begin
                    timer_d = '0;
                    state_d = StReleasing;
                end else if (win_done) begin
                    acc_x_d = '0;
                    acc_y_d = '0;
                    cnt_d   = '0;
`ifdef TOUCH_FILTER_MOVE_EN
                    if (move_hit) begin
                        push      = 1'b1;
                        push_type = EvMove;
                        push_x    = avg_x;
                        push_y    = avg_y;
                        last_x_d  = avg_x;
                        last_y_d  = avg_y;
                    end
`endif
                end else if (sample) begin
                    acc_x_d = sum_x;
                    acc_y_d = sum_y;
                    cnt_d   = cnt_inc;
                end
            end
            StReleasing: begin
                // Contact returning keeps the partial window; only the timer restarts.
                if (bus.iTouch) begin
                    timer_d = '0;
                    state_d = StPressed;
                end else if (timer_q == TmrLast) begin
                    push      = 1'b1;
                    push_type = EvRelease;
                    push_x    = last_x_q;
                    push_y    = last_y_q;
                    acc_x_d   = '0;
                    acc_y_d   = '0;
                    cnt_d     = '0;
                    timer_d   = '0;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Extra pointer MSB distinguishes full from empty.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop_ok = bus.iEVT_POP & ~empty;
    assign wr_en  = push & (~full | pop_ok);
    assign drop   = push & full & ~pop_ok;
    assign head   = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.iCLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= StIdle;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            last_x_q <= '0;
            last_y_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            last_x_q <= last_x_d;
            last_y_q <= last_y_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {push_type, push_x, push_y};
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign bus.oEVT_VALID = ~empty;
    assign bus.oEVT_TYPE  = empty ? 2'b00 : head[25:24];
    assign bus.oEVT_X     = empty ? 12'd0 : head[23:12];
    assign bus.oEVT_Y     = empty ? 12'd0 : head[11:0];
    assign bus.oTOUCHING  = (state_q == StPressed) || (state_q == StReleasing);
    assign bus.oOVERFLOW  = ovf_q;
endmodule

// File: tb/tb_touch_event_filter.sv
// Scoreboard bench for touch_event_filter: directed touch sequences push expected
// events; a monitor pops the FIFO and compares each head against the queue.
module tb_touch_event_filter;
    localparam int unsigned RelCycles = 1000;
    localparam logic [1:0]  EvPress   = 2'b01;
    localparam logic [1:0]  EvMove    = 2'b10;
    localparam logic [1:0]  EvRelease = 2'b11;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    bit   auto_pop;
    bit   force_pop;
    bit   do_pop;
    logic [25:0] exp_q[$];
    logic [25:0] exp_e;

    touch_event_filter_if bus ();

    touch_event_filter #(
        .AVG_LOG2       (2),
        .RELEASE_CYCLES (RelCycles),
        .MOVE_THRESH    (8),
        .FIFO_AW        (2)
    ) u_dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: pops whenever popping is enabled and compares with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            do_pop = (auto_pop || force_pop) && bus.oEVT_VALID && rst_n;
            if (do_pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got type=%0d x=%0d y=%0d required none",
                             bus.oEVT_TYPE, bus.oEVT_X, bus.oEVT_Y);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({bus.oEVT_TYPE, bus.oEVT_X, bus.oEVT_Y} !== exp_e) begin
                        failures++;
                        $display("FAIL event_head got type=%0d x=%0d y=%0d required type=%0d x=%0d y=%0d",
                                 bus.oEVT_TYPE, bus.oEVT_X, bus.oEVT_Y,
                                 exp_e[25:24], exp_e[23:12], exp_e[11:0]);
                    end
                end
            end
            bus.iEVT_POP = do_pop;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic [1:0] t, input logic [11:0] x, input logic [11:0] y);
        exp_q.push_back({t, x, y});
    endtask

    task automatic send_sample(input logic [11:0] x, input logic [11:0] y, input bit pop_too);
        @(negedge clk);
        bus.iTouch     = 1'b1;
        bus.iTOUCH_IRQ = 1'b1;
        bus.iX_COORD   = x;
        bus.iY_COORD   = y;
        force_pop      = pop_too;
        @(negedge clk);
        bus.iTOUCH_IRQ = 1'b0;
        force_pop      = 1'b0;
    endtask

    task automatic press(input logic [11:0] x, input logic [11:0] y, input bit pop_last);
        for (int i = 0; i < 3; i++) send_sample(x, y, 1'b0);
        send_sample(x, y, pop_last);
    endtask

    task automatic release_touch();
        @(negedge clk);
        bus.iTouch = 1'b0;
        repeat (RelCycles + 5) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.oEVT_VALID) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0 || bus.oEVT_VALID) begin
            failures++;
            $display("FAIL %s got pending=%0d valid=%0d required pending=0 valid=0",
                     name, exp_q.size(), bus.oEVT_VALID);
        end
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        bus.iCLR_OVF = 1'b1;
        @(negedge clk);
        bus.iCLR_OVF = 1'b0;
        #2;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        auto_pop       = 1'b0;
        force_pop      = 1'b0;
        rst_n          = 1'b0;
        bus.iTouch     = 1'b0;
        bus.iTOUCH_IRQ = 1'b0;
        bus.iX_COORD   = '0;
        bus.iY_COORD   = '0;
        bus.iEVT_POP   = 1'b0;
        bus.iCLR_OVF   = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_valid", 32'(bus.oEVT_VALID), 0);
        check("rst_type", 32'(bus.oEVT_TYPE), 0);
        check("rst_xy", {8'd0, bus.oEVT_X, bus.oEVT_Y}, 0);
        check("rst_touching", 32'(bus.oTOUCHING), 0);
        check("rst_overflow", 32'(bus.oOVERFLOW), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        auto_pop = 1'b1;

        // Averaged press: (100+104+108+112)/4 = 106
        expect_evt(EvPress, 12'd106, 12'd200);
        send_sample(12'd100, 12'd200, 1'b0);
        send_sample(12'd104, 12'd200, 1'b0);
        send_sample(12'd108, 12'd200, 1'b0);
        send_sample(12'd112, 12'd200, 1'b0);
        wait_drain("press_avg");
        check("press_touching", 32'(bus.oTOUCHING), 1);

        // Short lift does not release; full lift releases exactly after RelCycles
        auto_pop = 1'b0;
        @(negedge clk);
        bus.iTouch = 1'b0;
        repeat (100) @(negedge clk);
        bus.iTouch = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        check("short_lift_valid", 32'(bus.oEVT_VALID), 0);
        check("short_lift_touching", 32'(bus.oTOUCHING), 1);
        expect_evt(EvRelease, 12'd106, 12'd200);
        @(negedge clk);
        bus.iTouch = 1'b0;
        repeat (RelCycles) @(negedge clk);
        #2;
        check("release_not_early", 32'(bus.oEVT_VALID), 0);
        @(negedge clk);
        #2;
        check("release_on_time", 32'(bus.oEVT_VALID), 1);
        check("release_touching", 32'(bus.oTOUCHING), 0);
        auto_pop = 1'b1;
        wait_drain("release_drain");

        // Arming abort discards the partial window; IRQ without contact is ignored
        send_sample(12'd4000, 12'd4000, 1'b0);
        send_sample(12'd4000, 12'd4000, 1'b0);
        send_sample(12'd4000, 12'd4000, 1'b0);
        @(negedge clk);
        bus.iTouch     = 1'b0;
        bus.iTOUCH_IRQ = 1'b1;
        bus.iX_COORD   = 12'd4000;
        @(negedge clk);
        bus.iTOUCH_IRQ = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("abort_valid", 32'(bus.oEVT_VALID), 0);
        check("abort_touching", 32'(bus.oTOUCHING), 0);
        expect_evt(EvPress, 12'd300, 12'd400);
        press(12'd300, 12'd400, 1'b0);
        wait_drain("fresh_window");
        expect_evt(EvRelease, 12'd300, 12'd400);
        release_touch();
        wait_drain("abort_release");

        // MOVE above threshold only, and only when the feature is built in
        expect_evt(EvPress, 12'd500, 12'd600);
        press(12'd500, 12'd600, 1'b0);
`ifdef TOUCH_FILTER_MOVE_EN
        expect_evt(EvMove, 12'd509, 12'd600);
`endif
        press(12'd509, 12'd600, 1'b0);
        press(12'd515, 12'd600, 1'b0);
`ifdef TOUCH_FILTER_MOVE_EN
        expect_evt(EvRelease, 12'd509, 12'd600);
`else
        expect_evt(EvRelease, 12'd500, 12'd600);
`endif
        release_touch();
        wait_drain("move_sequence");

        // Fill FIFO, overflow, clear, then push+pop while full
        auto_pop = 1'b0;
        expect_evt(EvPress, 12'd10, 12'd20);
        press(12'd10, 12'd20, 1'b0);
        expect_evt(EvRelease, 12'd10, 12'd20);
        release_touch();
        expect_evt(EvPress, 12'd30, 12'd40);
        press(12'd30, 12'd40, 1'b0);
        expect_evt(EvRelease, 12'd30, 12'd40);
        release_touch();
        #2;
        check("full_valid", 32'(bus.oEVT_VALID), 1);
        check("full_head_x", 32'(bus.oEVT_X), 10);
        check("full_no_ovf", 32'(bus.oOVERFLOW), 0);
        press(12'd50, 12'd60, 1'b0);
        #2;
        check("drop_press_ovf", 32'(bus.oOVERFLOW), 1);
        check("drop_head_stable", 32'(bus.oEVT_X), 10);
        clear_ovf();
        check("clear_ovf", 32'(bus.oOVERFLOW), 0);
        release_touch();
        #2;
        check("drop_release_ovf", 32'(bus.oOVERFLOW), 1);
        clear_ovf();
        check("clear_ovf2", 32'(bus.oOVERFLOW), 0);
        expect_evt(EvPress, 12'd70, 12'd80);
        press(12'd70, 12'd80, 1'b1);
        #2;
        check("full_push_pop_ovf", 32'(bus.oOVERFLOW), 0);
        check("full_push_pop_valid", 32'(bus.oEVT_VALID), 1);
        auto_pop = 1'b1;
        wait_drain("fifo_order");
        expect_evt(EvRelease, 12'd70, 12'd80);
        release_touch();
        wait_drain("fifo_release");

        // Asynchronous reset with events queued
        auto_pop = 1'b0;
        expect_evt(EvPress, 12'd1, 12'd2);
        press(12'd1, 12'd2, 1'b0);
        expect_evt(EvRelease, 12'd1, 12'd2);
        release_touch();
        expect_evt(EvPress, 12'd3, 12'd4);
        press(12'd3, 12'd4, 1'b0);
        @(negedge clk);
        #2;
        check("queued_before_reset", 32'(bus.oEVT_VALID), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.oEVT_VALID), 0);
        check("async_rst_type", 32'(bus.oEVT_TYPE), 0);
        check("async_rst_xy", {8'd0, bus.oEVT_X, bus.oEVT_Y}, 0);
        check("async_rst_touching", 32'(bus.oTOUCHING), 0);
        exp_q.delete();
        @(negedge clk);
        bus.iTouch = 1'b0;
        rst_n      = 1'b1;
        auto_pop   = 1'b1;
        expect_evt(EvPress, 12'd7, 12'd8);
        press(12'd7, 12'd8, 1'b0);
        wait_drain("post_reset_press");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
